count_day: RTL and testbench
============================

// Module: count_day
//
// PURPOSE
//   BCD day-of-month counter for the century clock. Advances one day per
//   en_d tick from the hour stage. Wraps at the month's real length
//   (28/29/30/31), using the current month digits and the leap flag.
//   pulse_d drives en_mo of count_month, so this block feeds the month counter.
//
// PARAMETERS
//   RST_DAY_TEN   2'd0  day_ten value loaded on reset
//   RST_DAY_UNIT  4'd1  day_unit value loaded on reset (reset day = 01)
//   LEAP_EN       1     1: February has 29 days when leap=1; 0: leap ignored, Feb = 28
//
// PORTS
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous reset, active-high
//   en_d         in   1  day-advance tick, one cycle wide (from hour carry)
//   month_ten    in   2  current month, tens digit (from count_month)
//   month_unit   in   4  current month, units digit (from count_month)
//   leap         in   1  current year is a leap year (from year stage)
//   ld           in   1  synchronous load strobe (time-set path)
//   ld_day_ten   in   2  BCD tens digit to load
//   ld_day_unit  in   4  BCD units digit to load
//   day_ten      out  2  day-of-month, tens digit (0..3)
//   day_unit     out  4  day-of-month, units digit (0..9)
//   pulse_d      out  1  month carry; one-cycle pulse to count_month en_mo
//
// BEHAVIOUR
//   - Reset (async, rst=1): day_ten=RST_DAY_TEN, day_unit=RST_DAY_UNIT, pulse_d=0.
//     The outputs hold while rst=1. Operation resumes on the first clk edge after release.
//   - Days-in-month (dim), combinational from month = 10*month_ten + month_unit:
//       month 1,3,5,7,8,10,12 -> 31
//       month 4,6,9,11 -> 30
//       month 2 -> 29 if (LEAP_EN && leap), else 28
//       invalid month (0, >12, non-BCD) -> 31
//   - Priority at each clk edge: ld > en_d > hold.
//   - Count (en_d=1, ld=0). Let day = 10*day_ten + day_unit.
//       day <  dim: day+1 in BCD. Unit 9 -> 0 with ten+1. pulse_d=0.
//       day >= dim: day -> 01, and pulse_d=1 in the same cycle that 01 appears.
//       The >= case covers a day left over from a longer month after a month load.
//   - Latency: outputs and pulse_d update on the clk edge that samples en_d
//     (one register stage). pulse_d is registered and never combinational.
//   - pulse_d is high for exactly one cycle per wrap. In every other cycle it is 0,
//     including load cycles and hold cycles.
//   - Load (ld=1):
//       load value 00, or ld_day_unit > 9: ignored; the register holds.
//       load value > dim: saturates to dim (e.g. 31 in April loads as 30).
//       otherwise: loaded exactly.
//       pulse_d=0. An en_d in the same cycle is dropped (the tick is not deferred).
//   - Month or leap inputs changing with no en_d do not alter the day outputs.
//     The new dim only applies at the next en_d or ld.
//   - Back-to-back en_d (every cycle) is legal. Each cycle advances one day.
//   - Outputs are always valid BCD: day_ten in 0..3, day_unit in 0..9,
//     and day is never 00 after reset.
//
// TESTING
//   1. rst=1 mid-count at day 17 -> outputs go to 01 asynchronously, pulse_d=0;
//      release, en_d=1 -> 02 on the next edge.
//   2. month=01, en_d held high 31 cycles from 01 -> 02..31, then 01 with
//      pulse_d=1 for that single cycle only.
//   3. month=02, leap=0: load 28, one en_d -> 01 + pulse_d.
//      leap=1: 28 -> 29 with no pulse, then 29 -> 01 + pulse.
//      LEAP_EN=0 build with leap=1: 28 -> 01 + pulse.
//   4. month=04: load 31 -> day reads 30. Load 00 -> holds 30.
//      Load unit=4'hA -> holds 30. ld and en_d in the same cycle with load 15
//      -> day=15, pulse_d=0.
//   5. Load 31 in month 01, then change the month to 06, then one en_d
//      -> 01 + pulse_d=1.
//   6. Chain with count_month (pulse_d -> en_mo), 400 days with correct dim
//      per month -> month advances exactly on each pulse_d. Check the
//      12 -> 01 wrap.

Source files
------------

// File: rtl/count_day_if.sv
// rtl/count_day_if.sv - day counter bus: advance/load controls, month context, day outputs
interface count_day_if;
  logic       en_d;
  logic [1:0] month_ten;
  logic [3:0] month_unit;
  logic       leap;
  logic       ld;
  logic [1:0] ld_day_ten;
  logic [3:0] ld_day_unit;
  logic [1:0] day_ten;
  logic [3:0] day_unit;
  logic       pulse_d;

  modport master (
    output en_d, month_ten, month_unit, leap, ld, ld_day_ten, ld_day_unit,
    input  day_ten, day_unit, pulse_d
  );

  modport slave (
    input  en_d, month_ten, month_unit, leap, ld, ld_day_ten, ld_day_unit,
    output day_ten, day_unit, pulse_d
  );
endinterface

// File: rtl/count_day.sv
// rtl/count_day.sv - BCD day-of-month counter with month-length wrap and month carry pulse
module count_day #(
  parameter logic [1:0] RST_DAY_TEN  = 2'd0,
  parameter logic [3:0] RST_DAY_UNIT = 4'd1,
  parameter bit         LEAP_EN      = 1'b1
) (
  input logic         clk,
  input logic         rst,
  count_day_if.slave  bus
);

  logic [1:0] day_ten_q, day_ten_nxt;
  logic [3:0] day_unit_q, day_unit_nxt;
  logic       pulse_q, pulse_nxt;

  logic [5:0] dim;
  logic [1:0] dim_ten;
  logic [3:0] dim_unit;
  logic [5:0] day_bin;
  logic [5:0] ld_bin;
  logic       ld_ok;

  // Month length; any month code outside 01..12 is treated as a 31-day month.
  always_comb begin
    dim      = 6'd31;
    dim_ten  = 2'd3;
    dim_unit = 4'd1;
    case ({bus.month_ten, bus.month_unit})
      6'h04, 6'h06, 6'h09, 6'h11: begin
        dim      = 6'd30;
        dim_ten  = 2'd3;
        dim_unit = 4'd0;
      end
      6'h02: begin
        dim_ten = 2'd2;
        if (LEAP_EN && bus.leap) begin
          dim      = 6'd29;
          dim_unit = 4'd9;
        end else begin
          dim      = 6'd28;
          dim_unit = 4'd8;
        end
      end
      default: begin
        dim      = 6'd31;
        dim_ten  = 2'd3;
        dim_unit = 4'd1;
      end
    endcase
  end

  always_comb begin
    day_bin = 6'(day_ten_q) * 6'd10 + 6'(day_unit_q);
    ld_bin  = 6'(bus.ld_day_ten) * 6'd10 + 6'(bus.ld_day_unit);
    ld_ok   = (ld_bin != 6'd0) && (bus.ld_day_unit <= 4'd9);
  end

  // Load wins over the tick; a tick arriving with a load is simply lost.
  always_comb begin
    day_ten_nxt  = day_ten_q;
    day_unit_nxt = day_unit_q;
    pulse_nxt    = 1'b0;
    if (bus.ld) begin
      if (ld_ok) begin
        if (ld_bin > dim) begin
          day_ten_nxt  = dim_ten;
          day_unit_nxt = dim_unit;
        end else begin
          day_ten_nxt  = bus.ld_day_ten;
          day_unit_nxt = bus.ld_day_unit;
        end
      end
    end else if (bus.en_d) begin
      // >= rather than == so a day stranded past a shorter month still wraps.
      if (day_bin >= dim) begin
        day_ten_nxt  = 2'd0;
        day_unit_nxt = 4'd1;
        pulse_nxt    = 1'b1;
      end else if (day_unit_q == 4'd9) begin
        day_ten_nxt  = day_ten_q + 2'd1;
        day_unit_nxt = 4'd0;
      end else begin
        day_unit_nxt = day_unit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_ten_q  <= RST_DAY_TEN;
      day_unit_q <= RST_DAY_UNIT;
      pulse_q    <= 1'b0;
    end else begin
      day_ten_q  <= day_ten_nxt;
      day_unit_q <= day_unit_nxt;
      pulse_q    <= pulse_nxt;
    end
  end

  assign bus.day_ten  = day_ten_q;
  assign bus.day_unit = day_unit_q;
  assign bus.pulse_d  = pulse_q;

endmodule

// File: tb/tb_count_day.sv
// tb/tb_count_day.sv - scoreboard bench for count_day, leap-enabled and leap-disabled builds side by side
module tb_count_day;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  count_day_if bus_a ();
  count_day_if bus_b ();

  count_day #(.LEAP_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  count_day #(.LEAP_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.en_d        = bus_a.en_d;
  assign bus_b.month_ten   = bus_a.month_ten;
  assign bus_b.month_unit  = bus_a.month_unit;
  assign bus_b.leap        = bus_a.leap;
  assign bus_b.ld          = bus_a.ld;
  assign bus_b.ld_day_ten  = bus_a.ld_day_ten;
  assign bus_b.ld_day_unit = bus_a.ld_day_unit;

  typedef struct {
    int da;
    int db;
    bit pa;
    bit pb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   day_a = 1;
  int   day_b = 1;
  int   cur_mt = 0;
  int   cur_mu = 1;
  bit   cur_leap = 1'b0;
  int   model_pulses = 0;
  int   dut_pulses = 0;
  int   year_wraps = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int bcd(input int d);
    return ((d / 10) << 4) | (d % 10);
  endfunction

  function automatic int dim_of(input int mt, input int mu, input bit lp);
    int m;
    m = mt * 10 + mu;
    if (mu > 9 || m < 1 || m > 12) return 31;
    if (m == 2) return lp ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic void apply(inout int day, output bit p, input bit e, input bit l,
                                input int lt, input int lu, input int dim);
    int v;
    p = 1'b0;
    if (l) begin
      v = lt * 10 + lu;
      if (!(lu > 9 || v == 0)) day = (v > dim) ? dim : v;
    end else if (e) begin
      if (day >= dim) begin
        day = 1;
        p   = 1'b1;
      end else begin
        day++;
      end
    end
  endfunction

  // One clock of stimulus; expected post-edge outputs of both builds go to the scoreboard.
  task automatic step(input bit e, input bit l, input int lt, input int lu);
    exp_t x;
    @(negedge clk);
    bus_a.en_d        = e;
    bus_a.ld          = l;
    bus_a.ld_day_ten  = 2'(lt);
    bus_a.ld_day_unit = 4'(lu);
    bus_a.month_ten   = 2'(cur_mt);
    bus_a.month_unit  = 4'(cur_mu);
    bus_a.leap        = cur_leap;
    apply(day_a, x.pa, e, l, lt, lu, dim_of(cur_mt, cur_mu, cur_leap));
    apply(day_b, x.pb, e, l, lt, lu, dim_of(cur_mt, cur_mu, 1'b0));
    x.da = day_a;
    x.db = day_b;
    if (x.pa) model_pulses++;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      if (bus_a.pulse_d) dut_pulses++;
      chk("day_a", {bus_a.day_ten, bus_a.day_unit}, bcd(x.da));
      chk("pulse_a", int'(bus_a.pulse_d), int'(x.pa));
      chk("day_b", {bus_b.day_ten, bus_b.day_unit}, bcd(x.db));
      chk("pulse_b", int'(bus_b.pulse_d), int'(x.pb));
    end
  end

  task automatic set_month(input int m);
    cur_mt = m / 10;
    cur_mu = m % 10;
  endtask

  initial begin
    bus_a.en_d = 1'b0;
    bus_a.ld = 1'b0;
    bus_a.ld_day_ten = 2'd0;
    bus_a.ld_day_unit = 4'd0;
    bus_a.month_ten = 2'd0;
    bus_a.month_unit = 4'd1;
    bus_a.leap = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_day_a", {bus_a.day_ten, bus_a.day_unit}, 'h01);
    chk("rst_pulse_a", int'(bus_a.pulse_d), 0);
    chk("rst_day_b", {bus_b.day_ten, bus_b.day_unit}, 'h01);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-count at day 17, then resume counting.
    set_month(1);
    step(1'b0, 1'b1, 1, 7);
    step(1'b1, 1'b0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus_a.en_d = 1'b0;
    #1;
    chk("async_rst_day_a", {bus_a.day_ten, bus_a.day_unit}, 'h01);
    chk("async_rst_pulse_a", int'(bus_a.pulse_d), 0);
    chk("async_rst_day_b", {bus_b.day_ten, bus_b.day_unit}, 'h01);
    day_a = 1;
    day_b = 1;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 0, 0);

    // January full lap: 02..31 then 01 with one carry pulse.
    step(1'b0, 1'b1, 0, 1);
    for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);

    // February, with and without leap.
    set_month(2);
    cur_leap = 1'b0;
    step(1'b0, 1'b1, 2, 8);
    step(1'b1, 1'b0, 0, 0);
    cur_leap = 1'b1;
    step(1'b0, 1'b1, 2, 8);
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 2, 9);
    step(1'b1, 1'b0, 0, 0);

    // April load saturation, rejected loads, load beating a tick.
    set_month(4);
    step(1'b0, 1'b1, 3, 1);
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b1, 3, 10);
    step(1'b1, 1'b1, 1, 5);
    step(1'b0, 1'b0, 0, 0);

    // Day 31 stranded by a switch to June wraps on the next tick.
    set_month(1);
    step(1'b0, 1'b1, 3, 1);
    set_month(6);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);

    // Chained with a month counter that follows the model's carry: 400 days.
    set_month(1);
    cur_leap = 1'b0;
    step(1'b0, 1'b1, 0, 1);
    model_pulses = 0;
    dut_pulses = 0;
    for (int days = 0; days < 400; ) begin
      bit e;
      int m;
      e = ($urandom % 3) != 0;
      step(e, 1'b0, 0, 0);
      if (e) days++;
      if (sb[$].pa) begin
        m = cur_mt * 10 + cur_mu;
        if (m == 12) begin
          m = 1;
          year_wraps++;
          cur_leap = $urandom % 2;
        end else begin
          m++;
        end
        set_month(m);
      end
    end
    step(1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #2;
    chk("chain_pulse_count", dut_pulses, model_pulses);
    chk("chain_year_wraps", int'(year_wraps > 0), 1);

    // Random mix including invalid month codes, loads and leap flips.
    for (int i = 0; i < 600; i++) begin
      cur_mt = $urandom % 4;
      cur_mu = ($urandom % 4 == 0) ? ($urandom % 16) : ($urandom % 10);
      if ($urandom % 8 == 0) cur_leap = ~cur_leap;
      step(($urandom % 2) == 1, ($urandom % 8) == 0, $urandom % 4, $urandom % 16);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
